// File: rtl/ls_control_unit.sv
// Hardwired control sequencer: one control step per clock, fetch/decode/execute for
// ld, ldi, st, add, sub, and, or, nop, halt. Strobes depend on the state, the IR fields and mem_ready.
module ls_control_unit #(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           i_clk,
    input  logic           i_clr,
    input  logic           i_run,
    input  logic [IRW-1:0] i_ir,
    input  logic           i_mem_ready,
    output logic           o_PCout,
    output logic           o_MARin,
    output logic           o_incPC,
    output logic           o_Zin,
    output logic           o_ZLowOut,
    output logic           o_PCin,
    output logic           o_read,
    output logic           o_write,
    output logic           o_MDRin,
    output logic           o_MDRout,
    output logic           o_IRin,
    output logic           o_Gra,
    output logic           o_Grb,
    output logic           o_Grc,
    output logic           o_Rin,
    output logic           o_Rout,
    output logic           o_BAout,
    output logic           o_Yin,
    output logic           o_Cout,
    output logic [OPW-1:0] o_alu_op,
    output logic           o_busy,
    output logic           o_halted,
    output logic           o_instr_done,
    output logic           o_illegal,
    output logic [3:0]     o_dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_DEC  = 4'd4,
        S_A3   = 4'd5,
        S_A4   = 4'd6,
        S_A5   = 4'd7,
        S_A6   = 4'd8,
        S_A7   = 4'd9,
        S_R3   = 4'd10,
        S_R4   = 4'd11,
        S_R5   = 4'd12,
        S_END  = 4'd13,
        S_HALT = 4'd14
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [OPW-1:0] ALU_ADD = 5'b00001;
    localparam logic [OPW-1:0] ALU_SUB = 5'b00010;
    localparam logic [OPW-1:0] ALU_AND = 5'b01010;
    localparam logic [OPW-1:0] ALU_OR  = 5'b01011;

    state_t         r_state;
    state_t         w_next;
    state_t         w_after_instr;
    logic [OPW-1:0] w_opcode;

    assign w_opcode      = i_ir[IRW-1 -: OPW];
    assign w_after_instr = i_run ? S_T0 : S_IDLE;
    assign o_dbg_state   = r_state;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // mem_ready is a completion strobe: a memory step holds its strobes every cycle
    // and advances only in the cycle mem_ready=1, which is the single completion cycle.
    always_comb begin
        w_next       = r_state;
        o_PCout      = 1'b0;
        o_MARin      = 1'b0;
        o_incPC      = 1'b0;
        o_Zin        = 1'b0;
        o_ZLowOut    = 1'b0;
        o_PCin       = 1'b0;
        o_read       = 1'b0;
        o_write      = 1'b0;
        o_MDRin      = 1'b0;
        o_MDRout     = 1'b0;
        o_IRin       = 1'b0;
        o_Gra        = 1'b0;
        o_Grb        = 1'b0;
        o_Grc        = 1'b0;
        o_Rin        = 1'b0;
        o_Rout       = 1'b0;
        o_BAout      = 1'b0;
        o_Yin        = 1'b0;
        o_Cout       = 1'b0;
        o_alu_op     = '0;
        o_halted     = 1'b0;
        o_instr_done = 1'b0;
        o_illegal    = 1'b0;
        o_busy       = (r_state != S_IDLE) && (r_state != S_HALT);

        case (r_state)
            S_IDLE: begin
                if (i_run) w_next = S_T0;
            end
            S_T0: begin
                o_PCout = 1'b1;
                o_MARin = 1'b1;
                o_incPC = 1'b1;
                o_Zin   = 1'b1;
                w_next  = S_T1;
            end
            S_T1: begin
                o_ZLowOut = 1'b1;
                o_read    = 1'b1;
                o_MDRin   = 1'b1;
                // PC is loaded only on the completing cycle so it advances exactly once.
                if (i_mem_ready) begin
                    o_PCin = 1'b1;
                    w_next = S_T2;
                end
            end
            S_T2: begin
                o_MDRout = 1'b1;
                o_IRin   = 1'b1;
                w_next   = S_DEC;
            end
            S_DEC: begin
                case (w_opcode)
                    OP_LD, OP_LDI, OP_ST:          w_next = S_A3;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_R3;
                    OP_NOP:                        w_next = S_END;
                    OP_HALT:                       w_next = S_HALT;
                    default: begin
                        o_illegal = 1'b1;
                        w_next    = S_END;
                    end
                endcase
            end
            S_A3: begin
                o_Grb   = 1'b1;
                o_BAout = 1'b1;
                o_Yin   = 1'b1;
                w_next  = S_A4;
            end
            S_A4: begin
                o_Cout   = 1'b1;
                o_Zin    = 1'b1;
                o_alu_op = ALU_ADD;
                w_next   = S_A5;
            end
            S_A5: begin
                o_ZLowOut = 1'b1;
                if (w_opcode == OP_LDI) begin
                    o_Gra        = 1'b1;
                    o_Rin        = 1'b1;
                    o_instr_done = 1'b1;
                    w_next       = w_after_instr;
                end else begin
                    o_MARin = 1'b1;
                    w_next  = S_A6;
                end
            end
            S_A6: begin
                if (w_opcode == OP_ST) begin
                    o_Gra   = 1'b1;
                    o_Rout  = 1'b1;
                    o_MDRin = 1'b1;
                    w_next  = S_A7;
                end else begin
                    o_read  = 1'b1;
                    o_MDRin = 1'b1;
                    if (i_mem_ready) w_next = S_A7;
                end
            end
            S_A7: begin
                if (w_opcode == OP_ST) begin
                    o_write = 1'b1;
                    if (i_mem_ready) begin
                        o_instr_done = 1'b1;
                        w_next       = w_after_instr;
                    end
                end else begin
                    o_MDRout     = 1'b1;
                    o_Gra        = 1'b1;
                    o_Rin        = 1'b1;
                    o_instr_done = 1'b1;
                    w_next       = w_after_instr;
                end
            end
            S_R3: begin
                o_Grb  = 1'b1;
                o_Rout = 1'b1;
                o_Yin  = 1'b1;
                w_next = S_R4;
            end
            S_R4: begin
                o_Grc  = 1'b1;
                o_Rout = 1'b1;
                o_Zin  = 1'b1;
                case (w_opcode)
                    OP_ADD:  o_alu_op = ALU_ADD;
                    OP_SUB:  o_alu_op = ALU_SUB;
                    OP_AND:  o_alu_op = ALU_AND;
                    OP_OR:   o_alu_op = ALU_OR;
                    default: o_alu_op = '0;
                endcase
                w_next = S_R5;
            end
            S_R5: begin
                o_ZLowOut    = 1'b1;
                o_Gra        = 1'b1;
                o_Rin        = 1'b1;
                o_instr_done = 1'b1;
                w_next       = w_after_instr;
            end
            S_END: begin
                o_instr_done = 1'b1;
                w_next       = w_after_instr;
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
